// File: rtl/lcd_responder.sv
// lcd_responder: HD44780-style bus responder with 2x16 character buffer,
// display-control state, busy/status and data read-back.
module lcd_responder #(
  parameter int BUSY_CYC = 2000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [7:0] LCD_DATA,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  output logic [7:0] oLCD_DQ,
  output logic       oLCD_DQ_OE,
  input  logic [4:0] iCHAR_ADDR,
  output logic [7:0] oCHAR,
  output logic       oBUSY,
  output logic       oDISP_ON,
  output logic       oCURSOR_ON,
  output logic       oBLINK_ON,
  output logic [2:0] oFUNC,
  output logic       oWR_STB,
  output logic       oOVERRUN
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_BUSY  = 2'd3;
  localparam int CW = $clog2(BUSY_CYC + 33);
  logic          r_en_s1, r_en_s2, r_en_s3;
  logic          r_rs_s1, r_rs_s2, r_rw_s1, r_rw_s2;
  logic [7:0]    r_d_s1, r_d_s2;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [6:0]    r_ac;
  logic          r_id;
  logic [7:0]    r_buf [32];
  logic [7:0]    r_char;
  logic          r_disp, r_cur, r_blink, r_ovr;
  logic [2:0]    r_func;
  logic          r_cmd_rs;
  logic [7:0]    r_cmd_d;
  logic          w_fall, w_map_ok, w_busy;
  logic [4:0]    w_idx;
  logic [7:0]    w_rd_char;
  // Out-of-range addresses wrap to the start/end of the other line using the low 6 bits.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
    ac_step = up ? ((ac[5:0] >= 6'h27) ? {~ac[6], 6'h00} : ac + 7'd1)
                 : ((ac[5:0] == 6'h00) ? {~ac[6], 6'h27} : ac - 7'd1);
  endfunction
  assign w_fall     = r_en_s3 & ~r_en_s2;
  assign w_map_ok   = r_ac[5:4] == 2'b00;
  assign w_idx      = {r_ac[6], r_ac[3:0]};
  assign w_rd_char  = w_map_ok ? r_buf[w_idx] : 8'h20;
  assign w_busy     = r_state != S_IDLE;
  assign oBUSY      = w_busy;
  assign oWR_STB    = r_state == S_EXEC;
  assign oLCD_DQ_OE = r_rw_s2 & r_en_s2;
  assign oLCD_DQ    = oLCD_DQ_OE ? (r_rs_s2 ? w_rd_char : {w_busy, r_ac}) : 8'h00;
  assign oCHAR      = r_char;
  assign oDISP_ON   = r_disp;
  assign oCURSOR_ON = r_cur;
  assign oBLINK_ON  = r_blink;
  assign oFUNC      = r_func;
  assign oOVERRUN   = r_ovr;
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      {r_en_s1, r_en_s2, r_en_s3, r_rs_s1, r_rs_s2, r_rw_s1, r_rw_s2} <= '0;
      r_d_s1   <= '0;
      r_d_s2   <= '0;
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ac     <= '0;
      r_id     <= 1'b1;
      r_char   <= 8'h20;
      r_disp   <= 1'b0;
      r_cur    <= 1'b0;
      r_blink  <= 1'b0;
      r_ovr    <= 1'b0;
      r_func   <= 3'b100;
      r_cmd_rs <= 1'b0;
      r_cmd_d  <= '0;
      for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
    end else begin
      {r_en_s1, r_en_s2, r_en_s3} <= {LCD_EN, r_en_s1, r_en_s2};
      {r_rs_s1, r_rs_s2} <= {LCD_RS, r_rs_s1};
      {r_rw_s1, r_rw_s2} <= {LCD_RW, r_rw_s1};
      r_d_s1 <= LCD_DATA;
      r_d_s2 <= r_d_s1;
      r_char <= r_buf[iCHAR_ADDR];
      if (w_fall && r_rw_s2 && r_rs_s2) r_ac <= ac_step(r_ac, r_id);
      if (w_fall && !r_rw_s2 && w_busy) r_ovr <= 1'b1;
      case (r_state)
        S_IDLE: if (w_fall && !r_rw_s2) begin
          r_state  <= S_EXEC;
          r_cmd_rs <= r_rs_s2;
          r_cmd_d  <= r_d_s2;
        end
        S_EXEC: begin
          r_cnt   <= '0;
          r_state <= (!r_cmd_rs && r_cmd_d == 8'h01) ? S_CLEAR : S_BUSY;
          if (r_cmd_rs) begin
            if (w_map_ok) r_buf[w_idx] <= r_cmd_d;
            r_ac <= ac_step(r_ac, r_id);
          end else if (r_cmd_d[7]) r_ac <= r_cmd_d[6:0];
          else if (!r_cmd_d[6]) begin
            if (r_cmd_d[5]) r_func <= r_cmd_d[4:2];
            else if (r_cmd_d[4]) begin
              if (!r_cmd_d[3]) r_ac <= ac_step(r_ac, r_cmd_d[2]);
            end else if (r_cmd_d[3]) {r_disp, r_cur, r_blink} <= r_cmd_d[2:0];
            else if (r_cmd_d[2]) r_id <= r_cmd_d[1];
            else if (r_cmd_d[1]) r_ac <= '0;
            else if (r_cmd_d[0]) begin
              r_ac <= '0;
              r_id <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          r_buf[r_cnt[4:0]] <= 8'h20;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt[4:0] == 5'd31) begin
            r_state <= S_BUSY;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(BUSY_CYC - 1)) r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_responder.sv
// tb_lcd_responder: directed bus transfers against lcd_responder with
// hand-computed expectations (BUSY_CYC=4 so busy windows are short).
module tb_lcd_responder;
  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] lcd_data = '0;
  logic       lcd_rw = 1'b0, lcd_en = 1'b0, lcd_rs = 1'b0;
  logic [7:0] dq;
  logic       dq_oe;
  logic [4:0] char_addr = '0;
  logic [7:0] ch;
  logic       busy, disp_on, cursor_on, blink_on, wr_stb, overrun;
  logic [2:0] func;
  int         n_chk = 0, n_fail = 0, stb_cnt = 0;
  logic [7:0] q;
  logic       oe;
  logic [7:0] msg [7] = '{8'h57, 8'h65, 8'h6C, 8'h63, 8'h6F, 8'h6D, 8'h65};
  lcd_responder #(.BUSY_CYC(4)) dut (
    .iCLK(clk), .iRST(rst), .LCD_DATA(lcd_data), .LCD_RW(lcd_rw), .LCD_EN(lcd_en),
    .LCD_RS(lcd_rs), .oLCD_DQ(dq), .oLCD_DQ_OE(dq_oe), .iCHAR_ADDR(char_addr),
    .oCHAR(ch), .oBUSY(busy), .oDISP_ON(disp_on), .oCURSOR_ON(cursor_on),
    .oBLINK_ON(blink_on), .oFUNC(func), .oWR_STB(wr_stb), .oOVERRUN(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (wr_stb) stb_cnt <= stb_cnt + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Returns one negedge after the fall is visible inside the DUT.
  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs;
    lcd_rw = 1'b0;
    lcd_data = d;
    lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    lcd_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask
  task automatic write_wait(input logic rs, input logic [7:0] d);
    bus_write(rs, d);
    wait_idle();
  endtask
  task automatic bus_read(input logic rs, output logic [7:0] v, output logic o);
    @(negedge clk);
    lcd_rs = rs;
    lcd_rw = 1'b1;
    lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    v = dq;
    o = dq_oe;
    lcd_en = 1'b0;
    repeat (3) @(negedge clk);
    lcd_rw = 1'b0;
  endtask
  task automatic read_char(input logic [4:0] a, output logic [7:0] v);
    @(negedge clk);
    char_addr = a;
    @(negedge clk);
    v = ch;
  endtask
  initial begin
    int n, cnt, s0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_func", func, 3'b100);
    check("rst_char", ch, 8'h20);
    check("rst_dq", dq, 0);
    check("rst_oe", dq_oe, 0);
    check("rst_ctl", {disp_on, cursor_on, blink_on, wr_stb, overrun}, 0);
    rst = 1'b0;
    write_wait(0, 8'h38);
    check("func_set", func, 3'b110);
    bus_write(0, 8'h0C);
    @(negedge clk);
    check("stb_high", wr_stb, 1);
    check("busy_high", busy, 1);
    @(negedge clk);
    check("stb_low", wr_stb, 0);
    wait_idle();
    check("disp_ctl", {disp_on, cursor_on, blink_on}, 3'b100);
    write_wait(0, 8'h01);
    write_wait(0, 8'h06);
    write_wait(0, 8'h80);
    for (int i = 0; i < 7; i++) write_wait(1, msg[i]);
    for (int i = 0; i < 7; i++) begin
      read_char(5'(i), q);
      check("welcome", q, msg[i]);
    end
    read_char(7, q);
    check("idx7_blank", q, 8'h20);
    check("no_overrun", overrun, 0);
    write_wait(0, 8'hC0);
    bus_write(1, 8'h41);
    lcd_rs = 1'b0;
    lcd_rw = 1'b1;
    lcd_en = 1'b1;
    repeat (2) @(negedge clk);
    check("status_busy", dq, 8'hC1);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("status_idle", dq, 8'h41);
    lcd_en = 1'b0;
    repeat (3) @(negedge clk);
    lcd_rw = 1'b0;
    read_char(16, q);
    check("line2_char", q, 8'h41);
    write_wait(0, 8'hA7);
    write_wait(1, 8'h58);
    bus_read(0, q, oe);
    check("wrap_up", q, 8'h40);
    read_char(16, q);
    check("unmapped_drop", q, 8'h41);
    write_wait(0, 8'h04);
    write_wait(0, 8'h80);
    write_wait(1, 8'h5A);
    bus_read(0, q, oe);
    check("wrap_down", q, 8'h67);
    write_wait(0, 8'h06);
    s0 = stb_cnt;
    bus_write(0, 8'h80);
    lcd_rs = 1'b1;
    lcd_data = 8'h77;
    lcd_en = 1'b1;
    @(negedge clk);
    lcd_en = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    check("ovr_flag", overrun, 1);
    check("ovr_stb", stb_cnt - s0, 1);
    read_char(0, q);
    check("ovr_buf", q, 8'h5A);
    bus_read(0, q, oe);
    check("ovr_ac", q, 8'h00);
    write_wait(0, 8'h0F);
    bus_write(0, 8'h01);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else if (cnt > 0) break;
    end
    check("clear_cycles", cnt, 37);
    read_char(0, q);
    check("clear_buf0", q, 8'h20);
    read_char(16, q);
    check("clear_buf16", q, 8'h20);
    bus_read(0, q, oe);
    check("clear_ac", q, 8'h00);
    write_wait(1, 8'h4B);
    write_wait(0, 8'h14);
    bus_read(0, q, oe);
    check("shift_right", q, 8'h02);
    write_wait(0, 8'h10);
    bus_read(0, q, oe);
    check("shift_left", q, 8'h01);
    write_wait(0, 8'h18);
    bus_read(0, q, oe);
    check("shift_disp", q, 8'h01);
    write_wait(0, 8'h80);
    bus_read(1, q, oe);
    check("data_read", q, 8'h4B);
    check("data_read_oe", oe, 1);
    bus_read(0, q, oe);
    check("data_read_ac", q, 8'h01);
    write_wait(0, 8'h02);
    bus_read(0, q, oe);
    check("home_ac", q, 8'h00);
    check("dcb_on", {disp_on, cursor_on, blink_on}, 3'b111);
    check("ovr_sticky", overrun, 1);
    read_char(0, q);
    bus_write(0, 8'h20);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_func", func, 3'b100);
    check("mid_rst_char", ch, 8'h20);
    check("mid_rst_ctl", {disp_on, cursor_on, blink_on, wr_stb, overrun, dq_oe}, 0);
    check("mid_rst_dq", dq, 0);
    rst = 1'b0;
    read_char(0, q);
    check("rst_buf0", q, 8'h20);
    bus_read(0, q, oe);
    check("rst_ac", q, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_responder.md
# lcd_responder

Synthesizable HD44780-compatible responder for the 8-bit character-LCD bus: it sits on the LCD_DATA/LCD_RW/LCD_EN/LCD_RS pins where the panel would be and accepts the command/data writes our LCD initiator and controller issue. It decodes instructions and keeps a 2×16 character buffer plus display-control state, and it answers busy-flag and data reads. A host-side read port exposes the buffer for on-screen mirroring and for self-checking benches.

## Interface
- BUSY_CYC, 2000: iCLK cycles the busy flag stays set after each accepted instruction or data write (40 us at 50 MHz).
- iCLK  in  1  system clock; all logic on rising edge.
- iRST  in  1  synchronous, active-high reset.
- LCD_DATA  in  8  bus data from the initiator.
- LCD_RW  in  1  1 = read, 0 = write.
- LCD_EN  in  1  strobe; a transfer completes on its falling edge.
- LCD_RS  in  1  0 = instruction/status, 1 = data.
- oLCD_DQ  out  8  read-back data for the bus.
- oLCD_DQ_OE  out  1  drive enable for oLCD_DQ.
- iCHAR_ADDR  in  5  host buffer index: 0–15 is line 1, 16–31 is line 2.
- oCHAR  out  8  character at iCHAR_ADDR, registered.
- oBUSY  out  1  busy flag.
- oDISP_ON, oCURSOR_ON, oBLINK_ON  out  1 each  D, C and B bits of display control.
- oFUNC  out  3  {DL, N, F} from function set.
- oWR_STB  out  1  one-cycle pulse per committed write (instruction or data).
- oOVERRUN  out  1  sticky; a write arrived while busy.

## Operation
- **Synchronization**
  - LCD_EN, LCD_RS, LCD_RW and LCD_DATA each pass through 2 flops (s1, s2).
  - A third EN flop s3 provides edge detection: fall = s3 & ~s2.
  - A transfer uses the RS/RW/DATA values in s2 at the fall.
- **Address counter (AC)**
  - 7 bits, valid ranges 0x00–0x27 and 0x40–0x67.
  - Increment wraps 0x27→0x40 and 0x67→0x00.
  - Decrement wraps 0x00→0x67 and 0x40→0x27.
  - Set DDRAM to any other value: it is stored as written, and the next increment or decrement applies the nearest rule above using the low 6 bits.
- **Buffer mapping**
  - AC 0x00–0x0F maps to index 0–15; AC 0x40–0x4F maps to index 16–31.
  - Other AC values are not stored; writes there are discarded, but AC still advances.
- **Instruction decode** (RS=0, RW=0), by highest set bit:
  - 0x01 clear: all 32 entries ← 0x20, AC ← 0, I/D ← 1.
  - 0x02/03 home: AC ← 0.
  - 0x04–07 entry mode: I/D ← bit1; S is ignored.
  - 0x08–0F display control: D, C, B ← bits 2:0.
  - 0x10–1F shift: if S/C=0, AC moves right (bit2=1) or left; if S/C=1, nothing happens.
  - 0x20–3F function set: {DL, N, F} ← bits 4:2.
  - 0x40–7F CGRAM address: accepted, no effect.
  - 0x80–FF: AC ← bits 6:0.
- **Data write** (RS=1, RW=0): buf[map(AC)] ← DATA, then AC ± 1 per I/D.
- **Reads**
  - While s2 RW=1 and s2 EN=1: oLCD_DQ_OE=1.
  - oLCD_DQ = {busy, AC} when RS=0, or buf[map(AC)] (0x20 if unmapped) when RS=1.
  - A data read advances AC at the fall.
  - Reads are always serviced, even when busy.
- **State machine**
  - IDLE: a write fall goes to EXEC; a read fall only advances AC if it is a data read.
  - EXEC (1 cycle): commit the write, pulse oWR_STB; go to CLEAR if the command is 0x01, otherwise to BUSY.
  - CLEAR: 32 cycles, one entry per cycle (index 0..31), then BUSY.
  - BUSY: count BUSY_CYC cycles, then IDLE.
  - oBUSY = (state != IDLE).
- **Writes while busy**: ignored; oOVERRUN ← 1. No state change and no oWR_STB.

## Timing
- **Reset values**
  - AC=0, I/D=1, buffer all 0x20.
  - oLCD_DQ=0, oLCD_DQ_OE=0, oCHAR=0x20.
  - oBUSY=0, oDISP_ON/oCURSOR_ON/oBLINK_ON=0, oFUNC=3'b100.
  - oWR_STB=0, oOVERRUN=0; state IDLE; sync flops cleared to 0.
- **Reset mid-operation** (including CLEAR or BUSY): outputs return to reset values on the next edge.
- **Write commit latency**: let E0 be the first iCLK edge that samples LCD_EN low.
  - The fall is seen after E1.
  - EXEC runs after E2: oWR_STB is high for the cycle after E2.
  - The buffer, AC and control registers are updated at E3.
  - oBUSY rises after E2.
- **Busy duration**
  - Non-clear writes: 1 + BUSY_CYC cycles.
  - Clear: 1 + 32 + BUSY_CYC cycles.
- **oCHAR**: 1-cycle latency from iCHAR_ADDR. A same-cycle write to that entry returns the old value.
- **oLCD_DQ_OE**: follows LCD_EN by 2 edges. Initiators must hold EN high for at least 3 iCLK cycles on reads.
- **Input hold**: RS/RW/DATA must be stable from 2 cycles before the EN fall until 1 cycle after it.

## Test plan
- **Init plus line 1**: after reset, drive 0x38, 0x0C, 0x01, 0x06, 0x80 and then "Welcome" as data, waiting for busy between transfers → oFUNC=3'b110, oDISP_ON=1, oCURSOR_ON=0; oCHAR at index 0..6 reads "Welcome"; index 7 reads 0x20.
- **Line change**: write 0xC0 then data 0x41 → index 16 = 0x41; status read returns 0x41 with busy=0 after the busy period (0xC1 while still busy).
- **Wrap**: write 0xA7 (AC=0x27), data 0x58, then status read → AC=0x40; with I/D=0 from 0x00, one data write gives AC=0x67.
- **Overrun**: issue a data write 5 cycles after a previous commit → buffer unchanged, no oWR_STB, oOVERRUN=1 until iRST.
- **Clear timing**: with BUSY_CYC=4, write 0x01 → oBUSY high for exactly 37 cycles, all entries 0x20, AC=0.
- **Data read and reset**: write 0x80, then data-read → oLCD_DQ=buf[0] while EN is high, and AC=1 afterwards. Assert iRST during BUSY → next cycle oBUSY=0 and all outputs at reset values.
